npc_addi_datapath: RTL and testbench
====================================

// Module: npc_addi_datapath
// PURPOSE
// - Single-cycle execute datapath of the NPC core: decodes one RV32I instruction per cycle and executes it.
// - Contains the instruction decoder, the adder ALU and the 32-entry register file.
// - Executes ADDI and flags EBREAK; every other encoding is reported as illegal and has no side effects.
// - Sits after instruction fetch; the PC register and the EBREAK DPI hook stay in the top level.
// PARAMETERS
// - XLEN      32            data/register width
// - NREGS     32            register count (address width = $clog2(NREGS) = 5)
// - RST_VAL   32'h0         value loaded into x1..x31 on reset
// PORTS
// - clk         in   1     single clock; all state updates on rising edge
// - rst         in   1     asynchronous, active-low reset
// - inst        in   32    instruction word for the current cycle
// - alu_result  out  32    rs1 value + sign-extended imm (combinational)
// - reg_wen     out  1     1 when the current inst writes rd (legal ADDI with rd != 0)
// - is_ebreak   out  1     inst == 32'h0010_0073
// - illegal     out  1     inst is neither ADDI nor EBREAK
// - dbg_raddr   in   5     debug read address (verification/difftest)
// - dbg_rdata   out  32    debug read data, combinational, x0 reads 0
// BEHAVIOUR
// - Decode fields: opcode=inst[6:0], rd=inst[11:7], funct3=inst[14:12], rs1=inst[19:15].
// - Immediate: imm = {{20{inst[31]}}, inst[31:20]} (I-type sign extension).
// - ADDI: opcode 7'b0010011 and funct3 3'b000. reg_wen = 1 if rd != 0.
// - EBREAK: exact match 32'h00100073. is_ebreak=1, illegal=0, reg_wen=0.
// - All other encodings: illegal=1, reg_wen=0. alu_result is still computed but never written.
// - ALU: alu_result = rf[rs1] + imm, modulo 2^32. Carry and overflow are discarded; no flags.
// - Register file read port: combinational. rf[0] always reads 0.
// - Register file write: at posedge clk, if reg_wen then rf[rd] <= alu_result. Writes to x0 are dropped.
// - Read during write to the same register returns the OLD value (no bypass). The new value is visible the next cycle.
// - Reset (rst==0): x1..x31 <= RST_VAL immediately, independent of clk.
//   - While rst is low, writes are blocked.
//   - Outputs stay combinational functions of inst and the cleared register file.
// - Reset asserted mid-cycle cancels any pending write. The first write occurs on the first posedge after rst rises.
// - Outputs are purely combinational: zero-latency decode/execute, one-cycle write-back.
// - No handshake. One instruction is accepted every cycle.
// STRUCTURE
// - Package npc_pkg:
//   - OPC_OP_IMM = 7'b0010011
//   - F3_ADDI = 3'b000
//   - INST_EBREAK = 32'h00100073
//   - typedef logic [4:0] reg_addr_t
//   - typedef logic [31:0] word_t
// - Sub-module npc_regfile (NREGS x XLEN):
//   - one write port, two combinational read ports (rs1, debug)
//   - x0 hardwired to 0
//   - async active-low clear
// - Decoder and ALU are inline combinational logic in npc_addi_datapath.
// TESTING
// - Reset: pulse rst low between clock edges -> dbg_rdata == 0 for x0..x31 immediately, before any clk edge.
// - ADDI chain:
//   - addi x1,x0,5 (32'h00500093) -> alu_result=5, reg_wen=1, next cycle x1=5
//   - then addi x2,x1,-1 (32'hFFF08113) -> x2=4
// - x0 protection: addi x0,x0,7 (32'h00700013) -> reg_wen=0, x0 still reads 0.
// - Wrap:
//   - x1=32'h7FFFFFFF (via ADDI chain), then addi x3,x1,1 -> x3=32'h80000000
//   - x1=0, addi x4,x1,-1 -> x4=32'hFFFFFFFF
// - EBREAK/illegal:
//   - inst=32'h00100073 -> is_ebreak=1, reg_wen=0, registers unchanged
//   - inst=32'h00000033 (ADD) -> illegal=1, no write
// - Mid-cycle reset: x5 holds 9, drive addi x5,x5,1, assert rst before the edge -> x5=0 after reset, not 10.

Source files
------------

// File: rtl/npc_pkg.sv
// ----------------------------------------------------------------------------
// npc_pkg
// Shared encodings and types for the NPC execute datapath.
//   OPC_OP_IMM  : major opcode of the I-type ALU group
//   F3_ADDI     : funct3 selecting ADDI inside OP-IMM
//   INST_EBREAK : the one and only EBREAK encoding
//   reg_addr_t  : architectural register index
//   word_t      : machine word
// ----------------------------------------------------------------------------
package npc_pkg;

  localparam logic [6:0]  OPC_OP_IMM  = 7'b0010011;
  localparam logic [2:0]  F3_ADDI     = 3'b000;
  localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] word_t;

  // I-type immediate: inst[31:20] sign-extended to a full word.
  function automatic word_t imm_i(input word_t inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/npc_regfile.sv
// ----------------------------------------------------------------------------
// npc_regfile
// NREGS x XLEN register file, x0 hardwired to zero.
// Ports:
//   clk       : write clock (rising edge)
//   rst_n     : async active-low clear, x1..x(NREGS-1) <= RST_VAL
//   wen       : write enable; writes to address 0 are discarded
//   waddr     : write address
//   wdata     : write data
//   rs1_addr  : operand read address   -> rs1_data (combinational)
//   dbg_addr  : debug read address     -> dbg_data (combinational)
// Reads never bypass a same-cycle write: the stored (old) value is returned.
// ----------------------------------------------------------------------------
module npc_regfile
  import npc_pkg::*;
#(
  parameter int               XLEN    = 32,
  parameter int               NREGS   = 32,
  parameter logic [XLEN-1:0]  RST_VAL = {XLEN{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wen,
  input  logic [$clog2(NREGS)-1:0] waddr,
  input  logic [XLEN-1:0]          wdata,
  input  logic [$clog2(NREGS)-1:0] rs1_addr,
  output logic [XLEN-1:0]          rs1_data,
  input  logic [$clog2(NREGS)-1:0] dbg_addr,
  output logic [XLEN-1:0]          dbg_data
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0] rf_r [NREGS];

  // Storage: async clear of every entry, then clocked write of one entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        // Entry 0 is never written and never read back; keep it at zero.
        rf_r[i] <= (i == 0) ? {XLEN{1'b0}} : RST_VAL;
      end
    end else if (wen && (waddr != {AW{1'b0}})) begin
      rf_r[waddr] <= wdata;
    end
  end

  // Read ports: address 0 always yields zero regardless of stored contents.
  always_comb begin
    rs1_data = {XLEN{1'b0}};
    dbg_data = {XLEN{1'b0}};
    if (rs1_addr != {AW{1'b0}}) begin
      rs1_data = rf_r[rs1_addr];
    end else begin
      rs1_data = {XLEN{1'b0}};
    end
    if (dbg_addr != {AW{1'b0}}) begin
      dbg_data = rf_r[dbg_addr];
    end else begin
      dbg_data = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/npc_addi_datapath.sv
// ----------------------------------------------------------------------------
// npc_addi_datapath
// Single-cycle execute stage of the NPC core: decodes one RV32I instruction
// per cycle, executes ADDI, flags EBREAK and reports everything else illegal.
// Ports:
//   clk        : clock, register write-back on rising edge
//   rst        : async active-low reset (clears x1..x31 to RST_VAL)
//   inst       : instruction word for the current cycle
//   alu_result : rf[rs1] + sign-extended imm (combinational, always computed)
//   reg_wen    : legal ADDI with rd != 0
//   is_ebreak  : inst is exactly EBREAK
//   illegal    : inst is neither ADDI nor EBREAK
//   dbg_raddr  : debug read address
//   dbg_rdata  : debug read data (combinational, x0 reads 0)
// Decode and ALU are combinational; the only state is the register file.
// ----------------------------------------------------------------------------
module npc_addi_datapath
  import npc_pkg::*;
#(
  parameter int               XLEN    = 32,
  parameter int               NREGS   = 32,
  parameter logic [XLEN-1:0]  RST_VAL = {XLEN{1'b0}}
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [31:0]              inst,
  output logic [XLEN-1:0]          alu_result,
  output logic                     reg_wen,
  output logic                     is_ebreak,
  output logic                     illegal,
  input  logic [$clog2(NREGS)-1:0] dbg_raddr,
  output logic [XLEN-1:0]          dbg_rdata
);

  logic [6:0]      opcode_s;
  reg_addr_t       rd_s;
  logic [2:0]      funct3_s;
  reg_addr_t       rs1_s;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] rs1_data_s;
  logic            is_addi_s;

  assign opcode_s = inst[6:0];
  assign rd_s     = inst[11:7];
  assign funct3_s = inst[14:12];
  assign rs1_s    = inst[19:15];
  assign imm_s    = imm_i(inst);

  // Instruction classification and write-enable generation.
  always_comb begin
    is_addi_s = 1'b0;
    is_ebreak = 1'b0;
    illegal   = 1'b0;
    reg_wen   = 1'b0;
    if ((opcode_s == OPC_OP_IMM) && (funct3_s == F3_ADDI)) begin
      is_addi_s = 1'b1;
    end else begin
      is_addi_s = 1'b0;
    end
    if (inst == INST_EBREAK) begin
      is_ebreak = 1'b1;
    end else begin
      is_ebreak = 1'b0;
    end
    illegal = !is_addi_s && !is_ebreak;
    // rd == 0 is a legal ADDI (canonical NOP) but must not claim a write.
    if (is_addi_s && (rd_s != 5'd0)) begin
      reg_wen = 1'b1;
    end else begin
      reg_wen = 1'b0;
    end
  end

  // Adder ALU: wraps modulo 2^XLEN, carry and overflow are dropped.
  always_comb begin
    alu_result = rs1_data_s + imm_s;
  end

  npc_regfile #(
    .XLEN    (XLEN),
    .NREGS   (NREGS),
    .RST_VAL (RST_VAL)
  ) u_regfile (
    .clk      (clk),
    .rst_n    (rst),
    .wen      (reg_wen),
    .waddr    (rd_s),
    .wdata    (alu_result),
    .rs1_addr (rs1_s),
    .rs1_data (rs1_data_s),
    .dbg_addr (dbg_raddr),
    .dbg_data (dbg_rdata)
  );

endmodule

// File: tb/tb_npc_addi_datapath.sv
// ----------------------------------------------------------------------------
// tb_npc_addi_datapath
// Table of instructions with expected decode/ALU outputs, plus a queue of
// expected register contents checked one cycle after each instruction.
// A second instance with a non-zero reset value exercises the 32-bit wrap.
// ----------------------------------------------------------------------------
module tb_npc_addi_datapath;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic        wen;
    logic        ebreak;
    logic        illegal;
  } vec_t;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] val;
  } sb_t;

  logic        clk = 1'b0;
  logic        clk_en = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = 32'h0000_0013;
  logic [31:0] alu_result;
  logic        reg_wen, is_ebreak, illegal;
  logic [4:0]  dbg_raddr = 5'd0;
  logic [31:0] dbg_rdata;

  logic [31:0] inst2 = 32'h0010_8193;   // addi x3,x1,1
  logic [31:0] alu2;
  logic        wen2, eb2, ill2;
  logic [4:0]  dbg_raddr2 = 5'd3;
  logic [31:0] dbg_rdata2;

  int total = 0;
  int bad   = 0;

  vec_t        vecs [12];
  sb_t         sb_q [$];
  logic [31:0] model [32];

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  npc_addi_datapath dut (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst),
    .alu_result (alu_result),
    .reg_wen    (reg_wen),
    .is_ebreak  (is_ebreak),
    .illegal    (illegal),
    .dbg_raddr  (dbg_raddr),
    .dbg_rdata  (dbg_rdata)
  );

  npc_addi_datapath #(.RST_VAL(32'h7FFF_FFFF)) dut_wrap (
    .clk        (clk),
    .rst        (rst),
    .inst       (inst2),
    .alu_result (alu2),
    .reg_wen    (wen2),
    .is_ebreak  (eb2),
    .illegal    (ill2),
    .dbg_raddr  (dbg_raddr2),
    .dbg_rdata  (dbg_rdata2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  initial begin
    sb_t e;
    logic [4:0] rd;

    vecs[0]  = '{32'h0050_0093, 32'h0000_0005, 1'b1, 1'b0, 1'b0}; // addi x1,x0,5
    vecs[1]  = '{32'hFFF0_8113, 32'h0000_0004, 1'b1, 1'b0, 1'b0}; // addi x2,x1,-1
    vecs[2]  = '{32'h0070_0013, 32'h0000_0007, 1'b0, 1'b0, 1'b0}; // addi x0,x0,7
    vecs[3]  = '{32'h0010_0073, 32'h0000_0001, 1'b0, 1'b1, 1'b0}; // ebreak
    vecs[4]  = '{32'h0000_0033, 32'h0000_0000, 1'b0, 1'b0, 1'b1}; // add x0,x0,x0
    vecs[5]  = '{32'h0000_00B3, 32'h0000_0000, 1'b0, 1'b0, 1'b1}; // add x1,x0,x0
    vecs[6]  = '{32'h0010_A093, 32'h0000_0006, 1'b0, 1'b0, 1'b1}; // slti x1,x1,1
    vecs[7]  = '{32'h0000_0093, 32'h0000_0000, 1'b1, 1'b0, 1'b0}; // addi x1,x0,0
    vecs[8]  = '{32'hFFF0_8213, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0}; // addi x4,x1,-1
    vecs[9]  = '{32'h0090_0293, 32'h0000_0009, 1'b1, 1'b0, 1'b0}; // addi x5,x0,9
    vecs[10] = '{32'h7FF2_8313, 32'h0000_0808, 1'b1, 1'b0, 1'b0}; // addi x6,x5,2047
    vecs[11] = '{32'h8003_0393, 32'h0000_0008, 1'b1, 1'b0, 1'b0}; // addi x7,x6,-2048
    for (int i = 0; i < 32; i++) model[i] = 32'h0;

    // Reset with the clock stopped: all registers must read 0 at once.
    #3 rst = 1'b0;
    for (int i = 0; i < 32; i++) begin
      dbg_raddr = i[4:0];
      #1 chk($sformatf("rst_x%0d", i), dbg_rdata, 32'h0);
    end
    chk("wrap_alu_pre", alu2, 32'h8000_0000);
    #1 rst = 1'b1;
    #1 clk_en = 1'b1;

    foreach (vecs[i]) begin
      @(negedge clk);
      inst = vecs[i].inst;
      rd   = vecs[i].inst[11:7];
      dbg_raddr = rd;
      #1;
      chk($sformatf("v%0d_alu", i), alu_result, vecs[i].alu);
      chk($sformatf("v%0d_wen", i), {31'b0, reg_wen}, {31'b0, vecs[i].wen});
      chk($sformatf("v%0d_ebreak", i), {31'b0, is_ebreak}, {31'b0, vecs[i].ebreak});
      chk($sformatf("v%0d_illegal", i), {31'b0, illegal}, {31'b0, vecs[i].illegal});
      // Before the edge the destination still shows its old value.
      chk($sformatf("v%0d_old_rd", i), dbg_rdata, model[rd]);
      e.addr = rd;
      e.val  = vecs[i].wen ? vecs[i].alu : model[rd];
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
        chk("sb_empty", 32'd0, 32'd1);
      end else begin
        e = sb_q.pop_front();
        dbg_raddr = e.addr;
        #1 chk($sformatf("v%0d_wb_x%0d", i, e.addr), dbg_rdata, e.val);
        if (e.addr != 5'd0) model[e.addr] = e.val;
      end
    end

    // Untouched registers keep their values across ebreak/illegal.
    dbg_raddr = 5'd2;
    #1 chk("x2_kept", dbg_rdata, 32'h4);

    // Wrap instance: x1 = 7FFFFFFF from reset, x3 = x1 + 1.
    chk("wrap_x3", dbg_rdata2, 32'h8000_0000);
    chk("wrap_alu", alu2, 32'h8000_0000);

    // Mid-cycle reset cancels the pending addi x5,x5,1.
    @(negedge clk);
    inst = 32'h0012_8293;
    dbg_raddr = 5'd5;
    #1 chk("mid_alu", alu_result, 32'd10);
    chk("mid_wen", {31'b0, reg_wen}, 32'd1);
    #2 rst = 1'b0;
    #1 chk("mid_rst_x5", dbg_rdata, 32'h0);
    @(posedge clk);
    #1 chk("mid_blocked_x5", dbg_rdata, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("mid_alu_after", alu_result, 32'd1);
    chk("mid_x5_still0", dbg_rdata, 32'h0);
    @(posedge clk);
    #1 chk("mid_first_wb", dbg_rdata, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
